// File: rtl/disp_mux_pkg.sv
// Shared types and constants for the two-digit seven-segment multiplexer.
// Anode enables are active-low, so "off" is all ones.
package disp_mux_pkg;

    typedef enum logic [1:0] {
        BLANK0,
        SHOW0,
        BLANK1,
        SHOW1
    } disp_state_t;

    localparam logic [1:0] AN_OFF = 2'b11;
    localparam logic [1:0] AN_D0  = 2'b10;
    localparam logic [1:0] AN_D1  = 2'b01;

    // Anode pattern is a pure function of the state, so it can never glitch to 2'b00.
    function automatic logic [1:0] an_decode(input disp_state_t st);
        logic [1:0] r;
        r = AN_OFF;
        case (st)
            SHOW0:   r = AN_D0;
            SHOW1:   r = AN_D1;
            default: r = AN_OFF;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/disp_mux.sv
// Two-digit display multiplexer: BLANK0 -> SHOW0 -> BLANK1 -> SHOW1, with a
// blanking gap before each digit so the decoder output settles before its anode turns on.
module disp_mux
    import disp_mux_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [3:0]  digit0,
    input  logic [3:0]  digit1,
    output logic [3:0]  s,
    output logic [1:0]  an,
    output logic        frame_tick,
    output disp_state_t state
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - BLANK_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic          last;

    always_comb begin
        last = 1'b0;
        case (state)
            BLANK0, BLANK1: last = (cnt == BLANK_LAST);
            default:        last = (cnt == SHOW_LAST);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= BLANK0;
            cnt   <= '0;
            s     <= 4'h0;
        end else begin
            // Loading on every blank edge means the shown value is the one sampled on the final blank edge.
            if (state == BLANK0)
                s <= digit0;
            else if (state == BLANK1)
                s <= digit1;

            if (!en) begin
                state <= BLANK0;
                cnt   <= '0;
            end else if (last) begin
                cnt <= '0;
                case (state)
                    BLANK0:  state <= SHOW0;
                    SHOW0:   state <= BLANK1;
                    BLANK1:  state <= SHOW1;
                    default: state <= BLANK0;
                endcase
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign an         = an_decode(state);
    assign frame_tick = (state == SHOW1) && (cnt == SHOW_LAST);

endmodule

// File: doc/disp_mux.md
# disp_mux

Time-multiplexing driver for a two-digit common-anode seven-segment display. It sits directly upstream of `seven_segment`, presenting one 4-bit hex value at a time on `s`. It drives the two active-low anode enables so that each digit is lit in turn. A programmable blanking interval between digits keeps the decoder output settled before an anode turns on, which suppresses ghosting.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles per digit slot (blank + show). Must be > `BLANK_CYCLES`.
- `BLANK_CYCLES`, default 500: cycles per slot with both anodes off. Must be ≥ 1.
- `clk`  in  1  system clock
- `reset`  in  1  reset, synchronous, active-low; clock clk
- `en`  in  1  1 = multiplex; 0 = force blanking and restart at digit 0
- `digit0`  in  4  value for digit 0 (right)
- `digit1`  in  4  value for digit 1 (left)
- `s`  out  4  hex value to `seven_segment`
- `an`  out  2  anode enables, active-low; `an[0]` = digit 0
- `frame_tick`  out  1  one-cycle pulse on the last cycle of each complete frame

## Operation
- The FSM has four states, stepped by counter `cnt`:
  - BLANK0 → SHOW0 → BLANK1 → SHOW1 → BLANK0.
- BLANKx lasts `BLANK_CYCLES` cycles. SHOWx lasts `REFRESH_DIV - BLANK_CYCLES` cycles.
- `cnt` counts 0..len-1 within a state. It clears to 0 on each state transition.
- `cnt` width is `$clog2(REFRESH_DIV)` and must hold `max(BLANK_CYCLES, REFRESH_DIV-BLANK_CYCLES) - 1` without overflow.
- `an` decode (Moore, from the state register only):
  - BLANK0/BLANK1 → 2'b11
  - SHOW0 → 2'b10
  - SHOW1 → 2'b01
- `s` register:
  - On every clock edge while in BLANKx, `s <= digitx`.
  - `s` holds throughout SHOWx.
  - The displayed value is therefore `digitx` as sampled on the final BLANKx edge. Input changes during SHOWx take effect only after the next BLANKx.
- `frame_tick` = 1 exactly when state = SHOW1 and `cnt` = `REFRESH_DIV - BLANK_CYCLES - 1`.
- `en` = 0 (sampled at an edge):
  - next state BLANK0, `cnt` <= 0, `frame_tick` = 0
  - `s` continues loading `digit0`, because the FSM is in BLANK0
  - `en` rising resumes from a full-length BLANK0.

## Timing
- Reset (`reset` = 0 at an edge) loads: state BLANK0, `cnt` 0, `s` 4'h0. Outputs then read `an` 2'b11, `frame_tick` 0.
- Reset overrides `en` and any in-progress slot. Asserting reset mid-SHOW turns both anodes off on the next cycle.
- After the first edge with `reset` = 1 and `en` = 1:
  - BLANK0 occupies `BLANK_CYCLES` cycles, counting the reset-release cycle.
  - The first `an` = 2'b10 appears `BLANK_CYCLES` cycles after release.
- Full frame period = 2 × `REFRESH_DIV` cycles. `frame_tick` period is the same.
- No two anodes are ever low in the same cycle. Every SHOWx↔SHOWy change passes through ≥ 1 cycle of `an` = 2'b11.
- `s` is stable for the entire SHOWx interval.
- `s` changes only on edges taken in a BLANK state, and on reset.
- Simultaneous `en` = 0 and terminal count: `en` wins, giving BLANK0 with `cnt` 0 and no `frame_tick` on the following cycle. `frame_tick` is decoded combinationally in the current cycle, so it still reflects the current state.

## Structure
- Package `disp_mux_pkg`:
  - `typedef enum logic [1:0] {BLANK0, SHOW0, BLANK1, SHOW1} disp_state_t`
  - anode constants `AN_OFF` = 2'b11, `AN_D0` = 2'b10, `AN_D1` = 2'b01
- No sub-module; the counter and FSM are inline.
- The top level instantiates `disp_mux` feeding `seven_segment` (`s` → `s`).

## Test plan
(`REFRESH_DIV` = 8, `BLANK_CYCLES` = 2, clock 10 ns.)
- **Reset/startup:** hold `reset` = 0 for 3 cycles, then release with `en` = 1, `digit0` = 4'h3, `digit1` = 4'hA. Required:
  - `an` = 11 and `s` = 0 during reset
  - `an` = 11 for cycles 0–1, `an` = 10 with `s` = 3 for cycles 2–7
  - `an` = 11 for 8–9, `an` = 01 with `s` = A for 10–15
  - `frame_tick` high only in cycle 15
- **Steady state:** run 100 frames. Required:
  - `frame_tick` every 16 cycles
  - `an` never 2'b00
  - every SHOW interval exactly 6 cycles
- **Mid-slot input change:** change `digit0` 3→F in cycle 4 (SHOW0). Required:
  - `s` stays 3 through cycle 7
  - `s` = F for the next SHOW0 (cycles 18–23)
- **Enable drop:** drop `en` to 0 in cycle 11 (SHOW1) for 5 cycles. Required:
  - `an` = 11 from cycle 12 on, no `frame_tick`
  - after `en` = 1 returns: 2 BLANK0 cycles, then `an` = 10
- **Reset mid-operation:** assert `reset` = 0 for 1 cycle during SHOW1. Required:
  - next cycle `an` = 11, `s` = 0
  - the sequence restarts identically to the startup scenario
- **Parameter edge:** with `REFRESH_DIV` = 2, `BLANK_CYCLES` = 1. Required: alternating 1-cycle blank/show, `an` pattern 11,10,11,01 repeating, `frame_tick` every 4 cycles.
